sram_req_arbiter: RTL

SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

---
 rtl/sram_req_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter
//   Arbitrates NUM_REQ request ports onto one single-port SRAM. The search is
//   round-robin, and an owner can hold the SRAM for a burst of up to MAX_BURST
//   consecutive grants. Read data returns on a shared bus, tagged by a one-hot
//   rsp_valid.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   req_valid/req_ready           per-requester handshake (req_ready one-hot or zero)
//   req_we, req_addr, req_wdata   per-requester command, packed by slice
//   rsp_valid, rsp_rdata          one-hot read response, 2 cycles after handshake
//   mem_en/we/addr/wdata          registered SRAM command
//   mem_rdata                     SRAM read data, valid the cycle after mem_en
//   perf_conflict_cnt             cycles with >=2 requesters valid
//
// Build option
//   SRAM_ARB_PERF_EN : when defined, builds the saturating contention counter.
//                      Otherwise perf_conflict_cnt is tied to zero.
module sram_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic [31:0]                   perf_conflict_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

  logic               found;
  logic [IDX_W-1:0]   search_idx;
  logic               cont;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_idx;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_we;

  logic                  mem_en_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [NUM_REQ-1:0]    rd_pend_q, rsp_valid_q;

  // Round-robin search starting at rr_ptr. Because rr_ptr and the offset are
  // both below NUM_REQ, one conditional subtract is enough for the wrap.
  always_comb begin
    logic [IDX_W:0] sum;
    found      = 1'b0;
    search_idx = '0;
    sum        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      if (!found && req_valid[sum[IDX_W-1:0]]) begin
        found      = 1'b1;
        search_idx = sum[IDX_W-1:0];
      end
    end
  end

  // The current owner keeps the port while it stays valid and has burst budget left.
  assign cont = (state_q == BURST) && req_valid[owner_q] &&
                (burst_cnt_q < CNT_W'(MAX_BURST));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // FSM: next state. An exhausted or dropped burst re-arbitrates in the same cycle.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    if (cont) begin
      burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end else if (found) begin
      owner_d     = search_idx;
      burst_cnt_d = CNT_W'(1);
      rr_ptr_d    = (search_idx == IDX_W'(NUM_REQ - 1)) ? '0 : search_idx + IDX_W'(1);
      state_d     = (MAX_BURST > 1) ? BURST : IDLE;
    end else begin
      state_d     = IDLE;
    end
  end

  // FSM: outputs (grant decode and selected command)
  always_comb begin
    gnt_valid = !rst && (cont || found);
    gnt_idx   = cont ? owner_q : search_idx;
    req_ready = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt_idx == IDX_W'(k)) begin
        req_ready[k] = gnt_valid;
        sel_addr     = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata    = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        sel_we       = req_we[k];
      end
    end
  end

  // SRAM command register plus a 2-stage read-response tag pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_pend_q   <= '0;
      rsp_valid_q <= '0;
    end else begin
      mem_en_q    <= gnt_valid;
      mem_we_q    <= gnt_valid && sel_we;
      if (gnt_valid) begin
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
      end
      rd_pend_q   <= (gnt_valid && !sel_we) ? req_ready : '0;
      rsp_valid_q <= rd_pend_q;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  // The SRAM already registers its output, so read data passes straight
  // through. It is gated so the bus reads zero in idle cycles and during reset.
  assign rsp_rdata = (|rsp_valid_q) ? mem_rdata : '0;

`ifdef SRAM_ARB_PERF_EN
  logic [31:0] perf_q;
  logic        multi_valid;

  // Clearing the lowest set bit leaves a nonzero value only if >=2 bits were set.
  assign multi_valid = |(req_valid & (req_valid - NUM_REQ'(1)));

  always_ff @(posedge clk) begin
    if (rst)                              perf_q <= '0;
    else if (multi_valid && perf_q != '1) perf_q <= perf_q + 32'd1;
  end

  assign perf_conflict_cnt = perf_q;
`else
  assign perf_conflict_cnt = '0;
`endif

endmodule
